// File: rtl/serial_sub.sv
// Bit-serial subtractor: d = a - b - bi computed LSB first over WIDTH cycles
// with a single borrow flop, behind a start/busy/done handshake.
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] ar_q;   // minuend in, difference bits shifted in from the MSB side
  logic [WIDTH-1:0] b_q;
  logic            br_q;
  logic [CW-1:0]   cnt_q;
  logic            load, step, last;
  logic            d_bit, br_next;

  assign last    = (cnt_q == CW'(WIDTH - 1));
  assign d_bit   = ar_q[0] ^ b_q[0] ^ br_q;
  assign br_next = (~ar_q[0] & b_q[0]) | (~(ar_q[0] ^ b_q[0]) & br_q);

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // d/bo are written only on the last shift, so they hold through the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_q  <= '0;
      b_q   <= '0;
      br_q  <= 1'b0;
      cnt_q <= '0;
      d     <= '0;
      bo    <= 1'b0;
    end else if (load) begin
      ar_q  <= a;
      b_q   <= b;
      br_q  <= bi;
      cnt_q <= '0;
    end else if (step) begin
      ar_q  <= {d_bit, ar_q[WIDTH-1:1]};
      b_q   <= b_q >> 1;
      br_q  <= br_next;
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        d  <= {d_bit, ar_q[WIDTH-1:1]};
        bo <= br_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub (WIDTH=4): arithmetic reference model checked every
// cycle, plus directed operations with hand-computed literal results.
module tb_serial_sub;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bi = 1'b0;
  logic             busy, done, bo;
  logic [WIDTH-1:0] d;

  int n_checks = 0;
  int n_errors = 0;

  serial_sub #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bi   (bi),
    .busy (busy),
    .done (done),
    .d    (d),
    .bo   (bo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: cycles left until the result is due, and the result itself.
  int             m_left = 0;
  bit             m_done = 0;
  bit [WIDTH-1:0] m_d = '0, p_d = '0;
  bit             m_bo = 0, p_bo = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 0;
      m_d    = '0;
      m_bo   = 0;
    end else begin
      int diff;
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1;
          m_d    = p_d;
          m_bo   = p_bo;
        end
      end else if (start) begin
        diff   = int'(a) - int'(b) - int'(bi);
        p_d    = WIDTH'(diff);
        p_bo   = (diff < 0);
        m_left = WIDTH;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", int'(busy), int'(m_left > 0));
    check("done", int'(done), int'(m_done));
    check("d",    int'(d),    int'(m_d));
    check("bo",   int'(bo),   int'(m_bo));
  end

  // Returns the number of negedges until done is seen (bounded), counting busy cycles.
  task automatic wait_done(input string name, output int cyc, output int busy_n);
    cyc    = 0;
    busy_n = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_n++;
      @(negedge clk);
      cyc++;
    end
    check({name, "_timeout"}, int'(done), 1);
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tbi, input int exp_d, input int exp_bo);
    int cyc, busy_n;
    @(negedge clk);
    a = ta; b = tb; bi = tbi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(name, cyc, busy_n);
    check({name, "_latency"}, cyc, WIDTH);
    check({name, "_busy_cycles"}, busy_n, WIDTH);
    check({name, "_d"}, int'(d), exp_d);
    check({name, "_bo"}, int'(bo), exp_bo);
  endtask

  initial begin
    int cyc, busy_n;

    #12 rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_d", int'(d), 0);
    check("reset_bo", int'(bo), 0);

    run_op("9-3", 4'd9, 4'd3, 1'b0, 6, 0);
    run_op("3-9", 4'd3, 4'd9, 1'b0, 'hA, 1);
    run_op("0-0-1", 4'd0, 4'd0, 1'b1, 'hF, 1);
    run_op("F-F", 4'hF, 4'hF, 1'b0, 0, 0);

    // start pulsed with other operands while busy must be ignored
    @(negedge clk);
    a = 4'd9; b = 4'd3; bi = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", cyc, busy_n);
    check("ignore_d", int'(d), 6);
    @(negedge clk);
    check("ignore_no_restart", int'(busy), 0);

    // start held high: back-to-back 9-3 then 5-7
    @(negedge clk);
    a = 4'd9; b = 4'd3; bi = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 4'd5; b = 4'd7;
    wait_done("held1", cyc, busy_n);
    check("held1_d", int'(d), 6);
    check("held1_bo", int'(bo), 0);
    @(negedge clk);
    cyc = 1;
    while (!done && cyc < 20) begin
      check("held_d_stable", int'(d), 6);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("held_period", cyc, WIDTH + 1);
    check("held2_d", int'(d), 'hE);
    check("held2_bo", int'(bo), 1);

    // reset in the second SHIFT cycle aborts the operation
    @(negedge clk);
    @(negedge clk);
    a = 4'd9; b = 4'd3; bi = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_abort_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_d", int'(d), 0);
    check("abort_bo", int'(bo), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("abort_no_done", int'(done), 0);
    end
    run_op("7-2", 4'd7, 4'd2, 1'b0, 5, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
